// File: rtl/mmu_pte_port.sv
// mmu_pte_port
//   Bridges the MMU page walker's PTE strobes onto the DRAM controller
//   req/ack/rvalid port. Walker reads are launched on entry to the L1 (1)
//   or L0 (3) walker states. A writeback is launched in state 5 with
//   i_pte_we. A one-entry cache of the last L1 PTE lets repeated walks in
//   the same 4 MiB region skip the L1 DRAM read.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   i_pw_state        walker state (0 idle,1 L1,2 gap,3 L0,4 chk,5 upd,7 hit)
//   i_pte_addr/acs    PTE address and its qualifier
//   i_pte_we/wdata    PTE writeback request and value (state 5)
//   i_tlb_flush       invalidates the L1 PTE cache
//   o_busy/o_odata    walker handshake: busy, last PTE read
//   o_req/o_we/o_addr/o_wdata, i_ack/i_rvalid/i_rdata   DRAM port
module mmu_pte_port #(
    parameter int PTE_CACHE_EN = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [2:0]        i_pw_state,
    input  logic [ADDR_W-1:0] i_pte_addr,
    input  logic              i_pte_acs,
    input  logic              i_pte_we,
    input  logic [31:0]       i_pte_wdata,
    input  logic              i_tlb_flush,
    output logic              o_busy,
    output logic [31:0]       o_odata,
    output logic              o_req,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [31:0]       o_wdata,
    input  logic              i_ack,
    input  logic              i_rvalid,
    input  logic [31:0]       i_rdata
);
    localparam bit CACHE_ON = (PTE_CACHE_EN != 0);

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

    state_t            state, state_nx;
    logic [2:0]        r_prev_state;
    logic [ADDR_W-1:0] r_addr_q;
    logic              r_pend;
    logic              r_is_l1;     // outstanding read is an L1 read
    logic              c_vld;
    logic [ADDR_W-1:0] c_tag;
    logic [31:0]       c_data;

    logic start_rd, start_wr, c_hit, rd_done, fill, wt_hit;

    // Launches are suppressed while reset is held so o_busy drops
    // immediately even if the walker is still parked in a read state.
    assign start_rd = !RST &&
                      ((i_pw_state == 3'd1 && r_prev_state != 3'd1) ||
                       (i_pw_state == 3'd3 && r_prev_state != 3'd3));
    assign start_wr = !RST && i_pw_state == 3'd5 && i_pte_we && i_pte_acs;
    assign o_busy   = start_rd || start_wr || r_pend;

    // Hit lookup uses the address latched while the walker was presenting it.
    assign c_hit  = CACHE_ON && c_vld && i_pw_state == 3'd1 && c_tag == r_addr_q;
    assign fill   = CACHE_ON && rd_done && r_is_l1;
    assign wt_hit = state == IDLE && start_wr && c_vld && i_pte_addr == c_tag;

    always_comb begin
        state_nx = state;
        rd_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start_rd && !c_hit) state_nx = RD_REQ;
                else if (start_wr)      state_nx = WR_REQ;
            end
            RD_REQ: begin
                if (i_ack) begin
                    // Data may come back in the same cycle as the ack.
                    if (i_rvalid) begin
                        state_nx = IDLE;
                        rd_done  = 1'b1;
                    end else begin
                        state_nx = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (i_rvalid) begin
                    state_nx = IDLE;
                    rd_done  = 1'b1;
                end
            end
            WR_REQ: begin
                if (i_ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            r_prev_state <= 3'd0;
            r_addr_q     <= '0;
            r_pend       <= 1'b0;
            r_is_l1      <= 1'b0;
            o_req        <= 1'b0;
            o_we         <= 1'b0;
            o_addr       <= '0;
            o_wdata      <= '0;
            o_odata      <= '0;
        end else begin
            state        <= state_nx;
            r_prev_state <= i_pw_state;
            if (i_pte_acs) r_addr_q <= i_pte_addr;
            case (state)
                IDLE: begin
                    // Only a cache hit leaves r_pend set in IDLE; it lasts one cycle.
                    r_pend <= 1'b0;
                    if (start_rd) begin
                        r_pend <= 1'b1;
                        if (c_hit) begin
                            o_odata <= c_data;
                        end else begin
                            o_addr  <= r_addr_q;
                            o_we    <= 1'b0;
                            o_req   <= 1'b1;
                            r_is_l1 <= (i_pw_state == 3'd1);
                        end
                    end else if (start_wr) begin
                        r_pend  <= 1'b1;
                        o_addr  <= i_pte_addr;
                        o_wdata <= i_pte_wdata;
                        o_we    <= 1'b1;
                        o_req   <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (i_ack) o_req <= 1'b0;
                end
                WR_REQ: begin
                    if (i_ack) begin
                        o_req  <= 1'b0;
                        o_we   <= 1'b0;
                        r_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (rd_done) begin
                o_odata <= i_rdata;
                r_pend  <= 1'b0;
            end
        end
    end

    // L1 PTE cache: filled by completed L1 reads, kept coherent with
    // writebacks to the cached address, cleared by sfence.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            c_vld  <= 1'b0;
            c_tag  <= '0;
            c_data <= '0;
        end else begin
            if (i_tlb_flush) c_vld <= 1'b0;
            else if (fill)   c_vld <= 1'b1;
            if (fill) begin
                c_tag  <= o_addr;
                c_data <= i_rdata;
            end else if (wt_hit) begin
                c_data <= i_pte_wdata;
            end
        end
    end

    // A launch while a transaction is in flight is a walker protocol error.
    a_no_launch_busy: assert property (@(posedge CLK) disable iff (RST)
        (state != IDLE) |-> !(start_rd || start_wr));

endmodule

// File: tb/tb_mmu_pte_port.sv
module tb_mmu_pte_port;
    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  i_pw_state;
    logic [31:0] i_pte_addr;
    logic        i_pte_acs;
    logic        i_pte_we;
    logic [31:0] i_pte_wdata;
    logic        i_tlb_flush;
    logic        o_busy;
    logic [31:0] o_odata;
    logic        o_req;
    logic        o_we;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic        i_ack;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the cache is "the last completed L1 PTE read",
    // DRAM is a sparse word store.
    bit          m_vld  = 0;
    logic [31:0] m_tag  = '0;
    logic [31:0] m_data = '0;
    logic [31:0] mem [logic [31:0]];

    mmu_pte_port #(.PTE_CACHE_EN(1), .ADDR_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .i_pw_state(i_pw_state), .i_pte_addr(i_pte_addr), .i_pte_acs(i_pte_acs),
        .i_pte_we(i_pte_we), .i_pte_wdata(i_pte_wdata), .i_tlb_flush(i_tlb_flush),
        .o_busy(o_busy), .o_odata(o_odata), .o_req(o_req), .o_we(o_we),
        .o_addr(o_addr), .o_wdata(o_wdata),
        .i_ack(i_ack), .i_rvalid(i_rvalid), .i_rdata(i_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Walker read at level lvl (1 or 3). Called just after a clock edge.
    task automatic do_read(input int lvl, input logic [31:0] a,
                           input int ack_k, input int rv_k, input bit fl);
        logic [31:0] d;
        bit hit;
        hit = (lvl == 1) && m_vld && (m_tag == a);
        d = mem.exists(a) ? mem[a] : $urandom;
        mem[a] = d;
        i_pw_state = (lvl == 1) ? 3'd0 : 3'd2;
        i_pte_addr = a;
        i_pte_acs  = 1'b1;
        tick();
        i_pw_state = 3'(lvl);
        #1 chk("busy_entry", o_busy, 1);
        tick();
        i_pte_acs = 1'b0;
        if (hit) begin
            #1;
            chk("hit_req", o_req, 0);
            chk("hit_busy", o_busy, 1);
            chk("hit_data", o_odata, m_data);
            tick();
            chk("hit_req2", o_req, 0);
            chk("hit_done", o_busy, 0);
            chk("hit_data2", o_odata, m_data);
        end else begin
            #1;
            chk("miss_req", o_req, 1);
            chk("miss_addr", o_addr, a);
            chk("miss_we", o_we, 0);
            for (int k = 0; k <= rv_k; k++) begin
                if (k > 0) tick();
                i_ack       = (k == ack_k);
                i_rvalid    = (k == rv_k);
                i_rdata     = (k == rv_k) ? d : 32'($urandom);
                i_tlb_flush = fl && (k == rv_k);
                #1;
                chk("rd_busy", o_busy, 1);
                chk("rd_req", o_req, 32'(k <= ack_k));
            end
            tick();
            i_ack = 0; i_rvalid = 0; i_tlb_flush = 0;
            #1;
            chk("rd_done", o_busy, 0);
            chk("rd_data", o_odata, d);
            chk("rd_req_off", o_req, 0);
            if (lvl == 1) begin
                m_vld = 1; m_tag = a; m_data = d;
            end
            if (fl) m_vld = 0;
        end
        i_pw_state = 3'd0;
        tick();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] dw, input int ack_k);
        i_pw_state  = 3'd5;
        i_pte_addr  = a;
        i_pte_wdata = dw;
        i_pte_we    = 1'b1;
        i_pte_acs   = 1'b1;
        #1 chk("wr_busy_entry", o_busy, 1);
        tick();
        i_pte_we  = 1'b0;
        i_pte_acs = 1'b0;
        #1;
        chk("wr_req", o_req, 1);
        chk("wr_we", o_we, 1);
        chk("wr_addr", o_addr, a);
        chk("wr_wdata", o_wdata, dw);
        for (int k = 0; k <= ack_k; k++) begin
            if (k > 0) tick();
            i_ack = (k == ack_k);
            #1 chk("wr_busy", o_busy, 1);
        end
        tick();
        i_ack = 0;
        #1;
        chk("wr_done", o_busy, 0);
        chk("wr_req_off", o_req, 0);
        chk("wr_we_off", o_we, 0);
        if (m_vld && m_tag == a) m_data = dw;
        mem[a] = dw;
        i_pw_state = 3'd0;
        tick();
    endtask

    task automatic do_flush();
        i_tlb_flush = 1'b1;
        tick();
        i_tlb_flush = 1'b0;
        m_vld = 0;
    endtask

    initial begin
        logic [31:0] pool [4];
        pool[0] = 32'h0008_0400; pool[1] = 32'h0008_1400;
        pool[2] = 32'h0009_1008; pool[3] = 32'h0008_2400;

        RST = 1; i_pw_state = 0; i_pte_addr = 0; i_pte_acs = 0; i_pte_we = 0;
        i_pte_wdata = 0; i_tlb_flush = 0; i_ack = 0; i_rvalid = 0; i_rdata = 0;
        tick(); tick();
        chk("rst_req", o_req, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_odata", o_odata, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_we", o_we, 0);
        RST = 0;
        tick();

        // L1 miss, then the same walk hits.
        mem[32'h0008_0400] = 32'h2000_00CF;
        do_read(1, 32'h0008_0400, 1, 3, 0);
        do_read(1, 32'h0008_0400, 1, 3, 0);
        // Writeback coherence (first value equals the old one, second differs).
        do_write(32'h0008_0400, 32'h2000_00CF | 32'h0000_00C0, 1);
        do_read(1, 32'h0008_0400, 0, 0, 0);
        do_write(32'h0008_0400, 32'h2000_01CF, 0);
        do_read(1, 32'h0008_0400, 0, 0, 0);
        chk("wt_value", o_odata, 32'h2000_01CF);
        // Flush forces a miss.
        do_flush();
        do_read(1, 32'h0008_0400, 2, 2, 0);
        // L0 read with same-cycle ack+rvalid; no fill, so L1 to it misses.
        mem[32'h0009_1008] = 32'h0001_2C07;
        do_read(3, 32'h0009_1008, 0, 0, 0);
        chk("l0_data", o_odata, 32'h0001_2C07);
        do_read(1, 32'h0009_1008, 0, 1, 0);

        // Randomized walks against the model.
        for (int n = 0; n < 80; n++) begin
            int op, ak, rk;
            logic [31:0] a;
            op = $urandom_range(0, 9);
            ak = $urandom_range(0, 3);
            rk = ak + $urandom_range(0, 3);
            a  = pool[$urandom_range(0, 3)];
            if (op <= 4)      do_read(1, a, ak, rk, $urandom_range(0, 7) == 0);
            else if (op <= 6) do_read(3, a, ak, rk, 0);
            else if (op <= 8) do_write(a, $urandom, ak);
            else              do_flush();
        end

        // Reset while waiting for read data.
        i_pw_state = 3'd2; i_pte_addr = 32'h0009_2000; i_pte_acs = 1; tick();
        i_pw_state = 3'd3; tick();
        i_pte_acs = 0;
        #1 chk("rw_req", o_req, 1);
        i_ack = 1; tick(); i_ack = 0;
        #1 chk("rw_busy", o_busy, 1);
        RST = 1;
        #1;
        chk("rst_mid_req", o_req, 0);
        chk("rst_mid_busy", o_busy, 0);
        chk("rst_mid_odata", o_odata, 0);
        tick();
        i_pw_state = 3'd0;
        tick();
        RST = 0;
        tick();
        i_rvalid = 1; i_rdata = 32'hDEAD_BEEF;
        tick();
        i_rvalid = 0;
        #1;
        chk("late_rvalid_odata", o_odata, 0);
        chk("late_rvalid_busy", o_busy, 0);
        chk("late_rvalid_req", o_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
